// File: rtl/adi2axis_pack.sv
// rtl/adi2axis_pack.sv - packs ADC sample pairs into 64-bit words with arm/trigger alignment
// Optional overflow counter: define ADI2AXIS_PACK_OVF_CNT_EN.
module adi2axis_pack #(
    parameter int C_M_AXIS_TDATA_NUM_BYTES = 8
) (
    input  logic                                  AXIS_ACLK,
    input  logic                                  AXIS_ARESETN,
    input  logic [31:0]                           adc_data,
    input  logic                                  adc_valid,
    input  logic                                  arm,
    input  logic                                  trig_en,
    input  logic                                  trig,
    input  logic                                  ovf,
    output logic [C_M_AXIS_TDATA_NUM_BYTES*8-1:0] ddata,
    output logic                                  dvalid,
    output logic                                  dsync,
    output logic [31:0]                           stat
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t      state;
    logic        phase;
    logic [31:0] low;
    logic        arm_d;
    logic [15:0] ovf_cnt;

    logic abort;
    logic arm_rise;
    logic trig_hit;

    // arm low outranks everything else; arm_d resets low so arm held high out of reset re-arms
    assign abort    = !arm && (state != ST_IDLE);
    assign arm_rise = arm && !arm_d;
    assign trig_hit = arm && arm_d && (state == ST_ARMED) && adc_valid && (trig || !trig_en);

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state  <= ST_IDLE;
            phase  <= 1'b0;
            low    <= '0;
            ddata  <= '0;
            dvalid <= 1'b0;
            dsync  <= 1'b0;
            arm_d  <= 1'b0;
        end else begin
            arm_d  <= arm;
            dvalid <= 1'b0;
            if (abort) begin
                state <= ST_IDLE;
                phase <= 1'b0;
                low   <= '0;
                dsync <= 1'b0;
            end else if (arm_rise) begin
                state <= ST_ARMED;
                phase <= 1'b0;
                low   <= '0;
                dsync <= 1'b0;
            end else if (trig_hit) begin
                // trigger sample always lands in the low half, whatever was held
                low   <= adc_data;
                phase <= 1'b1;
                state <= ST_RUN;
            end else if (adc_valid) begin
                if (!phase) begin
                    low   <= adc_data;
                    phase <= 1'b1;
                end else begin
                    ddata  <= {adc_data, low};
                    dvalid <= 1'b1;
                    phase  <= 1'b0;
                    if (state == ST_RUN) begin
                        dsync <= 1'b1;
                    end
                end
            end
        end
    end

`ifdef ADI2AXIS_PACK_OVF_CNT_EN
    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            ovf_cnt <= '0;
        end else if (arm_rise) begin
            ovf_cnt <= '0;
        end else if (ovf && dsync && (ovf_cnt != 16'hFFFF)) begin
            ovf_cnt <= ovf_cnt + 16'd1;
        end
    end
`else
    logic unused_ovf;
    assign unused_ovf = ovf;
    assign ovf_cnt    = '0;
`endif

    assign stat = {ovf_cnt, 13'h0, state, phase};

endmodule

// File: tb/tb_adi2axis_pack.sv
// tb/tb_adi2axis_pack.sv - directed self-checking bench for adi2axis_pack
module tb_adi2axis_pack;

    logic        clk;
    logic        rst_n;
    logic [31:0] adc_data;
    logic        adc_valid;
    logic        arm;
    logic        trig_en;
    logic        trig;
    logic        ovf;
    logic [63:0] ddata;
    logic        dvalid;
    logic        dsync;
    logic [31:0] stat;

    int errors = 0;
    int checks = 0;
    int dv_cnt;

    adi2axis_pack #(.C_M_AXIS_TDATA_NUM_BYTES(8)) dut (
        .AXIS_ACLK   (clk),
        .AXIS_ARESETN(rst_n),
        .adc_data    (adc_data),
        .adc_valid   (adc_valid),
        .arm         (arm),
        .trig_en     (trig_en),
        .trig        (trig),
        .ovf         (ovf),
        .ddata       (ddata),
        .dvalid      (dvalid),
        .dsync       (dsync),
        .stat        (stat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic cyc(input logic v, input logic [31:0] d, input logic t);
        adc_valid = v;
        adc_data  = d;
        trig      = t;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; adc_valid = 1'b0; adc_data = '0; arm = 1'b0;
        trig_en = 1'b0; trig = 1'b0; ovf = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ddata", ddata, 64'h0);
        chk("rst_dvalid", {63'h0, dvalid}, 64'h0);
        chk("rst_dsync", {63'h0, dsync}, 64'h0);
        chk("rst_stat", {32'h0, stat}, 64'h0);

        // free-run start, trig_en=0
        #2 rst_n = 1'b1;
        arm = 1'b1;
        cyc(1'b0, 32'h0, 1'b0);
        chk("armed_stat", {32'h0, stat}, 64'h2);
        cyc(1'b1, 32'h11, 1'b0);
        chk("trig0_stat", {32'h0, stat}, 64'h5);
        chk("trig0_dvalid", {63'h0, dvalid}, 64'h0);
        cyc(1'b1, 32'h22, 1'b0);
        chk("w1_dvalid", {63'h0, dvalid}, 64'h1);
        chk("w1_ddata", ddata, 64'h00000022_00000011);
        chk("w1_dsync", {63'h0, dsync}, 64'h1);
        cyc(1'b1, 32'h33, 1'b0);
        chk("w1_nodv", {63'h0, dvalid}, 64'h0);
        chk("w1_hold", ddata, 64'h00000022_00000011);
        cyc(1'b1, 32'h44, 1'b0);
        chk("w2_ddata", ddata, 64'h00000044_00000033);
        chk("w2_dvalid", {63'h0, dvalid}, 64'h1);
        cyc(1'b0, 32'h0, 1'b0);
        chk("run_dsync", {63'h0, dsync}, 64'h1);

        // abort with held sample; arm low wins over a same-cycle packing event
        cyc(1'b1, 32'h55, 1'b0);
        arm = 1'b0;
        cyc(1'b1, 32'h66, 1'b0);
        chk("abort_dsync", {63'h0, dsync}, 64'h0);
        chk("abort_stat", {32'h0, stat}, 64'h0);
        chk("abort_dvalid", {63'h0, dvalid}, 64'h0);
        cyc(1'b0, 32'h0, 1'b0);
        chk("abort_dvalid2", {63'h0, dvalid}, 64'h0);
        // packing continues unsynchronised in IDLE
        cyc(1'b1, 32'h77, 1'b0);
        chk("idle_phase", {32'h0, stat}, 64'h1);
        cyc(1'b1, 32'h88, 1'b0);
        chk("idle_ddata", ddata, 64'h00000088_00000077);
        chk("idle_dvalid", {63'h0, dvalid}, 64'h1);
        chk("idle_dsync", {63'h0, dsync}, 64'h0);

        // triggered start; sample coincident with arm rise is dropped
        trig_en = 1'b1;
        arm = 1'b1;
        cyc(1'b1, 32'h99, 1'b1);
        chk("arm_rise_stat", {32'h0, stat}, 64'h2);
        cyc(1'b1, 32'h1, 1'b0);
        chk("armed_p1", {32'h0, stat}, 64'h3);
        cyc(1'b1, 32'h2, 1'b0);
        chk("armed_w_ddata", ddata, 64'h00000002_00000001);
        chk("armed_w_dvalid", {63'h0, dvalid}, 64'h1);
        chk("armed_w_dsync", {63'h0, dsync}, 64'h0);
        cyc(1'b1, 32'h3, 1'b0);
        cyc(1'b0, 32'h0, 1'b1);
        chk("trig_no_valid", {32'h0, stat}, 64'h3);
        cyc(1'b1, 32'hA, 1'b1);
        chk("trig_stat", {32'h0, stat}, 64'h5);
        chk("trig_dvalid", {63'h0, dvalid}, 64'h0);
        cyc(1'b1, 32'hB, 1'b0);
        chk("tw_ddata", ddata, 64'h0000000B_0000000A);
        chk("tw_dvalid", {63'h0, dvalid}, 64'h1);
        chk("tw_dsync", {63'h0, dsync}, 64'h1);

        // half-rate input: one word every 4 cycles, 1-cycle latency
        dv_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            cyc((i % 2) == 0, 32'hC0 + i, 1'b1);
            if (dvalid) dv_cnt++;
            if (i == 2) chk("half_lat", {63'h0, dvalid}, 64'h1);
            if (i == 3) chk("half_hold", ddata, 64'h000000C2_000000C0);
        end
        chk("half_rate", dv_cnt, 2);
        chk("half_last", ddata, 64'h000000C6_000000C4);

        // overflow counter
        ovf = 1'b1;
`ifdef ADI2AXIS_PACK_OVF_CNT_EN
        cyc(1'b0, 32'h0, 1'b0);
        chk("ovf_cnt1", {48'h0, stat[31:16]}, 64'h1);
        repeat (70000) cyc(1'b0, 32'h0, 1'b0);
        chk("ovf_sat", {48'h0, stat[31:16]}, 64'hFFFF);
`else
        repeat (5) cyc(1'b0, 32'h0, 1'b0);
        chk("ovf_off", {48'h0, stat[31:16]}, 64'h0);
`endif
        ovf = 1'b0;
        arm = 1'b0;
        cyc(1'b0, 32'h0, 1'b0);
        arm = 1'b1;
        trig_en = 1'b0;
        cyc(1'b0, 32'h0, 1'b0);
        chk("ovf_clr", {32'h0, stat}, 64'h2);

        // async reset mid-word in RUN
        cyc(1'b1, 32'h21, 1'b0);
        chk("pre_rst_stat", {32'h0, stat}, 64'h5);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ddata", ddata, 64'h0);
        chk("arst_stat", {32'h0, stat}, 64'h0);
        chk("arst_dsync", {63'h0, dsync}, 64'h0);
        #2 rst_n = 1'b1;
        cyc(1'b0, 32'h0, 1'b0);
        chk("rel_armed", {32'h0, stat}, 64'h2);
        chk("rel_dvalid", {63'h0, dvalid}, 64'h0);
        cyc(1'b1, 32'h31, 1'b0);
        cyc(1'b1, 32'h32, 1'b0);
        chk("rel_ddata", ddata, 64'h00000032_00000031);
        chk("rel_dsync", {63'h0, dsync}, 64'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
